// File: rtl/pmt_phase_histogrammer.sv
`default_nettype none
// ============================================================================
// Module   : pmt_phase_histogrammer
// Purpose  : PMT leading-edge detector with phase-rotated, saturating
//            sub-bin histogram counters, hit strobe and dead-time holdoff.
// Revision : 1.0  initial release
// ============================================================================
module pmt_phase_histogrammer #(
    parameter int CW = 32,
    parameter int NB = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NB-1:0]         pmt,
    input  logic [2:0]            phaseoffset,
    input  logic                  usefullwidth,
    input  logic                  vetopmtlast,
    input  logic [7:0]            deadticks,
    input  logic                  resethist,
    output logic [NB-1:0][CW-1:0] h,
    output logic                  hit,
    output logic [1:0]            hitbin,
    output logic                  dead
);

    localparam logic [CW-1:0] c_CNT_MAX = '1;

    logic [NB-1:0]         r_cur;
    logic                  r_prev3;
    logic [7:0]            r_deadcnt;
    logic [NB-1:0][CW-1:0] r_h;
    logic                  r_hit;
    logic [1:0]            r_hitbin;

    logic [NB-1:0]         w_pred;
    logic [NB-1:0]         w_succ;
    logic [NB-1:0]         w_qual;
    logic                  w_found;
    logic [1:0]            w_idx;
    logic                  w_accept;
    logic [1:0]            w_bin;
    logic                  w_unused;

    assign w_unused = phaseoffset[2];

    // Sub-bin 0 looks back into the previous word; sub-bin 3 looks ahead into
    // the word arriving on pmt this cycle.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_sub
            if (gi == 0) begin : g_pred_first
                assign w_pred[gi] = vetopmtlast & r_prev3;
            end else begin : g_pred_inner
                assign w_pred[gi] = r_cur[gi-1];
            end
            if (gi == NB-1) begin : g_succ_last
                assign w_succ[gi] = pmt[0];
            end else begin : g_succ_inner
                assign w_succ[gi] = r_cur[gi+1];
            end
            assign w_qual[gi] = r_cur[gi] & ~w_pred[gi] & (~usefullwidth | w_succ[gi]);
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int i = NB-1; i >= 0; i--) begin
            if (w_qual[i]) begin
                w_found = 1'b1;
                w_idx   = i[1:0];
            end
        end
    end

    assign w_accept = w_found & (r_deadcnt == 8'd0);
    assign w_bin    = w_idx + phaseoffset[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur     <= '0;
            r_prev3   <= 1'b0;
            r_deadcnt <= 8'd0;
            r_hit     <= 1'b0;
            r_hitbin  <= 2'd0;
        end else begin
            r_cur   <= pmt;
            r_prev3 <= r_cur[NB-1];
            r_hit   <= w_accept;
            if (w_accept) begin
                r_hitbin  <= w_bin;
                r_deadcnt <= deadticks;
            end else if (r_deadcnt != 8'd0) begin
                r_deadcnt <= r_deadcnt - 8'd1;
            end
        end
    end

    // A clear coincident with a hit wins; the hit is strobed but not counted.
    always_ff @(posedge clk) begin
        if (reset || resethist) begin
            r_h <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (w_accept && (w_bin == b[1:0]) && (r_h[b] != c_CNT_MAX)) begin
                    r_h[b] <= r_h[b] + CW'(1);
                end
            end
        end
    end

    assign h      = r_h;
    assign hit    = r_hit;
    assign hitbin = r_hitbin;
    assign dead   = (r_deadcnt != 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_pmt_phase_histogrammer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmt_phase_histogrammer
// Purpose  : Self-checking bench: directed vector table, corner sequences and
//            randomized stimulus against a stream-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pmt_phase_histogrammer;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       pmt = 4'd0;
    logic [2:0]       phaseoffset = 3'd0;
    logic             usefullwidth = 1'b0;
    logic             vetopmtlast = 1'b0;
    logic [7:0]       deadticks = 8'd0;
    logic             resethist = 1'b0;
    logic [3:0][31:0] h32;
    logic [3:0][3:0]  h4;
    logic             hit, hit_s;
    logic [1:0]       hitbin, hitbin_s;
    logic             dead, dead_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pmt_phase_histogrammer #(.CW(32), .NB(4)) dut (
        .clk(clk), .reset(reset), .pmt(pmt), .phaseoffset(phaseoffset),
        .usefullwidth(usefullwidth), .vetopmtlast(vetopmtlast),
        .deadticks(deadticks), .resethist(resethist),
        .h(h32), .hit(hit), .hitbin(hitbin), .dead(dead)
    );

    // Narrow instance so counter saturation is reachable in a short run.
    pmt_phase_histogrammer #(.CW(4), .NB(4)) dut_sat (
        .clk(clk), .reset(reset), .pmt(pmt), .phaseoffset(phaseoffset),
        .usefullwidth(usefullwidth), .vetopmtlast(vetopmtlast),
        .deadticks(deadticks), .resethist(resethist),
        .h(h4), .hit(hit_s), .hitbin(hitbin_s), .dead(dead_s)
    );

    // Reference model: word-stream view with timestamps for the holdoff.
    logic [3:0] m_word;
    logic       m_p3;
    longint     m_cnt [4];
    longint     m_e;
    longint     m_next_ok;
    bit         m_hit;
    int         m_bin;
    bit         m_dead;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [5:0] s;
        int         pos;
        pos = -1;
        if (reset) begin
            m_word = 4'd0; m_p3 = 1'b0; m_hit = 1'b0; m_bin = 0; m_next_ok = 0;
            for (int b = 0; b < 4; b++) m_cnt[b] = 0;
        end else begin
            s[0]   = vetopmtlast ? m_p3 : 1'b0;
            s[4:1] = m_word;
            s[5]   = pmt[0];
            for (int i = 0; i < 4; i++)
                if (pos < 0 && s[i+1] && !s[i] && (!usefullwidth || s[i+2])) pos = i;
            m_hit = (pos >= 0) && (m_e >= m_next_ok);
            if (m_hit) begin
                m_bin     = (pos + int'(phaseoffset) % 4) % 4;
                m_next_ok = m_e + longint'(deadticks) + 1;
            end
            if (resethist) begin
                for (int b = 0; b < 4; b++) m_cnt[b] = 0;
            end else if (m_hit) begin
                m_cnt[m_bin]++;
            end
            m_p3   = m_word[3];
            m_word = pmt;
        end
        m_dead = (m_e + 1 < m_next_ok);
        m_e++;
    endtask

    task automatic check_model();
        longint e32, e4;
        chk("model_hit", longint'(hit), longint'(m_hit));
        chk("model_dead", longint'(dead), longint'(m_dead));
        chk("model_hit_sat", longint'(hit_s), longint'(m_hit));
        if (m_hit) chk("model_hitbin", longint'(hitbin), longint'(m_bin));
        for (int b = 0; b < 4; b++) begin
            e32 = (m_cnt[b] > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt[b];
            e4  = (m_cnt[b] > 15) ? 15 : m_cnt[b];
            chk($sformatf("model_h32[%0d]", b), longint'(h32[b]), e32);
            chk($sformatf("model_h4[%0d]", b), longint'(h4[b]), e4);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic [3:0] p;
        logic [2:0] po;
        logic       u, v;
        logic [7:0] dt;
        logic       rh;
        logic       ehit;
        logic [1:0] ebin;
        logic       edead;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [3:0] p, input logic [2:0] po, input logic u, input logic v,
                       input logic [7:0] dt, input logic rh, input logic eh,
                       input logic [1:0] eb, input logic ed);
        vec_t r;
        r.p = p; r.po = po; r.u = u; r.v = v; r.dt = dt; r.rh = rh;
        r.ehit = eh; r.ebin = eb; r.edead = ed;
        tv.push_back(r);
    endtask

    initial begin
        m_word = 4'd0; m_p3 = 1'b0; m_e = 0; m_next_ok = 0;
        m_hit = 1'b0; m_bin = 0; m_dead = 1'b0;
        for (int b = 0; b < 4; b++) m_cnt[b] = 0;

        // basic binning
        add(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        add(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0);
        add(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0);
        add(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        // rotation
        add(4'b0001, 7, 0, 0, 0, 0, 0, 0, 0);
        add(4'b0000, 7, 0, 0, 0, 0, 1, 3, 0);
        // word-boundary continuation, veto on then off
        add(4'b1000, 0, 0, 1, 0, 0, 0, 0, 0);
        add(4'b0011, 0, 0, 1, 0, 0, 1, 3, 0);
        add(4'b0000, 0, 0, 1, 0, 0, 0, 0, 0);
        add(4'b0000, 0, 0, 1, 0, 0, 0, 0, 0);
        add(4'b1000, 0, 0, 0, 0, 0, 0, 0, 0);
        add(4'b0011, 0, 0, 0, 0, 0, 1, 3, 0);
        add(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0);
        add(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        // width qualification
        add(4'b0100, 0, 1, 0, 0, 0, 0, 0, 0);
        add(4'b0000, 0, 1, 0, 0, 0, 0, 0, 0);
        add(4'b1000, 0, 1, 0, 0, 0, 0, 0, 0);
        add(4'b0001, 0, 1, 0, 0, 0, 1, 3, 0);
        add(4'b0000, 0, 1, 0, 0, 0, 0, 0, 0);
        add(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        // dead time 3 with a pulse every word
        add(4'b0001, 0, 0, 0, 3, 0, 0, 0, 0);
        add(4'b0001, 0, 0, 0, 3, 0, 1, 0, 1);
        add(4'b0001, 0, 0, 0, 3, 0, 0, 0, 1);
        add(4'b0001, 0, 0, 0, 3, 0, 0, 0, 1);
        add(4'b0001, 0, 0, 0, 3, 0, 0, 0, 0);
        add(4'b0001, 0, 0, 0, 3, 0, 1, 0, 1);
        add(4'b0001, 0, 0, 0, 3, 0, 0, 0, 1);
        add(4'b0001, 0, 0, 0, 3, 0, 0, 0, 1);
        add(4'b0001, 0, 0, 0, 3, 0, 0, 0, 0);
        add(4'b0001, 0, 0, 0, 3, 0, 1, 0, 1);
        // deadticks change mid-holdoff leaves the running count alone
        add(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1);
        add(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1);
        add(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        // clear coincident with a hit
        add(4'b0100, 0, 0, 0, 0, 0, 0, 0, 0);
        add(4'b0000, 0, 0, 0, 0, 1, 1, 2, 0);

        reset = 1'b1;
        tick();
        tick();
        chk("reset_hit", longint'(hit), 0);
        chk("reset_dead", longint'(dead), 0);
        chk("reset_h0", longint'(h32[0]), 0);
        reset = 1'b0;

        foreach (tv[k]) begin
            pmt = tv[k].p; phaseoffset = tv[k].po; usefullwidth = tv[k].u;
            vetopmtlast = tv[k].v; deadticks = tv[k].dt; resethist = tv[k].rh;
            tick();
            chk($sformatf("tv%0d_hit", k), longint'(hit), longint'(tv[k].ehit));
            if (tv[k].ehit) chk($sformatf("tv%0d_bin", k), longint'(hitbin), longint'(tv[k].ebin));
            chk($sformatf("tv%0d_dead", k), longint'(dead), longint'(tv[k].edead));
        end
        for (int b = 0; b < 4; b++) chk($sformatf("clear_h[%0d]", b), longint'(h32[b]), 0);
        resethist = 1'b0;

        // saturation: 20 hits into bin 0
        pmt = 4'b0000; phaseoffset = 0; usefullwidth = 0; vetopmtlast = 0; deadticks = 0;
        resethist = 1'b1;
        tick();
        resethist = 1'b0;
        for (int n = 0; n < 20; n++) begin
            pmt = 4'b0001; tick();
            pmt = 4'b0000; tick();
        end
        chk("sat_h4_0", longint'(h4[0]), 15);
        chk("sat_h32_0", longint'(h32[0]), 20);

        // reset in the middle of a holdoff
        deadticks = 8'd5;
        pmt = 4'b0001; tick();
        pmt = 4'b0000; tick();
        chk("rst_dead_pre_hit", longint'(hit), 1);
        tick();
        chk("rst_dead_pre_dead", longint'(dead), 1);
        reset = 1'b1; tick();
        chk("rst_dead_post_dead", longint'(dead), 0);
        chk("rst_dead_post_hit", longint'(hit), 0);
        reset = 1'b0;
        pmt = 4'b0001; tick();
        pmt = 4'b0000; tick();
        chk("rst_dead_next_hit", longint'(hit), 1);
        chk("rst_dead_next_bin", longint'(hitbin), 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            pmt = 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                phaseoffset  = 3'($urandom);
                usefullwidth = 1'($urandom);
                vetopmtlast  = 1'($urandom);
                deadticks    = 8'($urandom_range(0, 6));
            end
            resethist = ($urandom_range(0, 60) == 0);
            reset     = ($urandom_range(0, 400) == 0);
            tick();
        end
        reset = 1'b0;
        resethist = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pmt_phase_histogrammer.md
# pmt_phase_histogrammer

Captures the 4-sub-bin PMT sample word delivered every `clk` and detects pulse leading edges, optionally qualified by width and by continuity with the previous word. Each accepted hit is binned by sub-bin phase, rotated by `phaseoffset`, into four saturating 32-bit counters. The counters drive the `h` inputs of the serial command processor, which reads them and pulses `resethist` (command 10). The block also emits a per-hit strobe for the output-firing logic and applies a configurable dead time.

## Interface
Parameters:
- `CW`, 32: counter width; must match the processor's `h` element width.
- `NB`, 4: sub-bins per sample word; fixed at 4, and the rotation logic relies on it.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pmt`  in  4  PMT sample word for this clock; bit0 is the earliest sub-bin, bit3 the latest.
- `phaseoffset`  in  3  bin rotation; only bits [1:0] are used.
- `usefullwidth`  in  1  when 1, require a 2-sub-bin-wide pulse.
- `vetopmtlast`  in  1  when 1, an edge continuing the previous word's bit3 is not a leading edge.
- `deadticks`  in  8  clocks of hit holdoff after an accepted hit.
- `resethist`  in  1  single-cycle pulse that clears all counters.
- `h`  out  4×CW  counters `h[0..3]`.
- `hit`  out  1  one-cycle strobe per accepted hit.
- `hitbin`  out  2  rotated bin of the current `hit`; valid only while `hit`=1.
- `dead`  out  1  high while the holdoff counter is non-zero.

## Operation
- **Stage 0 (capture):**
  - `cur <= pmt`; `prev3 <= cur[3]`.
- **Stage 1 (edge detect):** uses `cur`, `nxt0` (= the `pmt` word currently arriving) and `prev3`.
  - Sub-bin i is an edge when `cur[i]=1` and its predecessor is 0.
  - The predecessor of i>0 is `cur[i-1]`.
  - The predecessor of i=0 is `prev3` when `vetopmtlast=1`, and is taken as 0 when `vetopmtlast=0`.
- **Width qualification:**
  - When `usefullwidth=1`, an edge at i also requires its successor = 1.
  - The successor of i<3 is `cur[i+1]`; the successor of i=3 is `nxt0`.
  - When `usefullwidth=0`, every edge qualifies.
- **Selection:** only the lowest qualified i in a word is taken; at most one hit per word.
- **Dead time:**
  - A qualified edge is accepted only when `deadcnt==0`.
  - On acceptance, `deadcnt <= deadticks`; otherwise `deadcnt` decrements to 0 and holds there.
  - With `deadticks=0`, consecutive words may each produce a hit.
- **Binning:**
  - `bin = (i + phaseoffset[1:0]) mod 4`.
  - `h[bin]` increments by 1 and saturates at 2^CW−1 (no wrap).
- **Clear:** `resethist=1` zeroes all four counters. A hit accepted in the same cycle is still strobed on `hit` but is not counted (clear wins).
- **Config changes:** `phaseoffset`, `usefullwidth`, `vetopmtlast` and `deadticks` are sampled every cycle, with no synchronisation. A change applies to the word evaluated in that cycle; a change while `deadcnt≠0` does not alter the running count.
- **Reset:**
  - `cur`, `prev3` and `deadcnt` go to 0; `h[0..3]` to 0; `hit` to 0; `hitbin` to 0; `dead` to 0.
  - A pulse in flight at reset is discarded.
  - The first word after reset sees `prev3=0`.

## Timing
- Word W is presented on `pmt` during cycle n and registered into `cur` at edge n.
- W is evaluated during cycle n+1, with word n+1 on `pmt` as `nxt0`.
- `hit`, `hitbin` and the `h` increment register at edge n+1 and are visible in cycle n+2. Latency is 2 clocks from sample to counter.
- `dead` rises in the same cycle as `hit` when `deadticks>0`. It stays high for exactly `deadticks` cycles.
- `resethist` asserted during cycle m leaves `h=0` visible in cycle m+1.
- The processor latches `h` in the same cycle it raises `resethist`, so no count is lost between read and clear except a hit coincident with that clear edge.
- No backpressure; the block accepts one word every clock.

## Test plan
- **Basic binning:** reset; `pmt` = 0000, 0010, 0000; `phaseoffset=0`, `usefullwidth=0`, `deadticks=0` → one `hit` with `hitbin=1`; `h` = {0,1,0,0} two cycles after the 0010 word.
- **Rotation:** `phaseoffset=7`; single pulse `pmt=0001` → `hitbin=3`; `h[3]=1`.
- **Word-boundary continuation:** `pmt` = 1000, 0011 with `vetopmtlast=1` → exactly one hit (bin 3). With `vetopmtlast=0` → two hits (bins 3 then 0).
- **Width qualification:** `usefullwidth=1`; `pmt` = 0100 → no hit. `pmt` = 1000, 0001 → hit at bin 3, using `nxt0`.
- **Dead time:** `deadticks=3`; pulses 0001 every cycle → hits on words 0, 4, 8; `dead` high for 3 cycles after each hit.
- **Saturation and clear:**
  - Preload `h[0]=0xFFFFFFFE`; two hits in bin 0 → stays 0xFFFFFFFF.
  - `resethist` coincident with a hit → all `h`=0 next cycle; `hit` still pulses.
  - `reset` mid-dead-time → `dead=0` and next pulse accepted.
